rtlmem_arb: RTL and testbench

Round-robin arbiter that shares one port of a 3-cycle-latency block RAM (the 2-port shared read/write wrapper) among G_NREQ requesters. It grants one read or write per cycle, drives the memory port from registers, and tags each read through the pipeline so the data returns to the requester that issued it. It also sequences RAM clear: it stops new grants, drains outstanding reads, runs the memory clear handshake, then resumes.

---
 rtl/rtlmem_arb.sv | 92 +++++++++
 tb/tb_rtlmem_arb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rtlmem_arb.sv
// rtlmem_arb: round-robin arbiter sharing one block-RAM port, with read tagging and RAM-clear sequencing
module rtlmem_arb #(
  parameter int G_NREQ  = 4,
  parameter int G_ADDR  = 10,
  parameter int G_WIDTH = 16,
  parameter int G_LAT   = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clren,
  output logic                        clrrdy,
  input  logic [G_NREQ-1:0]           req_re,
  input  logic [G_NREQ-1:0]           req_we,
  input  logic [G_NREQ*G_ADDR-1:0]    req_ad,
  input  logic [G_NREQ*G_WIDTH-1:0]   req_di,
  output logic [G_NREQ-1:0]           req_gnt,
  output logic [G_NREQ-1:0]           rsp_vld,
  output logic [G_WIDTH-1:0]          rsp_do,
  output logic [G_ADDR-1:0]           memad,
  output logic                        memwe,
  output logic [G_WIDTH-1:0]          memdi,
  output logic                        memre,
  input  logic [G_WIDTH-1:0]          memdo,
  output logic                        mem_clren,
  input  logic                        mem_clrrdy
);
  localparam int IW = $clog2(G_NREQ);
  typedef enum logic [1:0] {RUN, DRAIN, CLR, WAIT} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ptr, ptr_nx, gnt_id;
  logic [G_NREQ-1:0] active;
  logic gnt_vld, gnt_wr, wait_first;
  logic [G_LAT:0] tag_vld;
  logic [IW-1:0] tag_id [G_LAT+1];
  // grants only in RUN, never in the cycle a clear is requested, and never while reset is held
  assign active  = (req_re | req_we) & {G_NREQ{rst_n && state == RUN && !clren}};
  assign gnt_wr  = gnt_vld & req_we[gnt_id];
  assign req_gnt = gnt_vld ? G_NREQ'(1) << gnt_id : '0;
  assign ptr_nx  = gnt_vld ? (gnt_id == IW'(G_NREQ - 1) ? '0 : gnt_id + 1'b1) : ptr;
  assign clrrdy  = state == RUN;
  assign rsp_vld = tag_vld[G_LAT] ? G_NREQ'(1) << tag_id[G_LAT] : '0;
  assign rsp_do  = |tag_vld ? memdo : '0;
  // round-robin pick: scan downward from the far end so the requester nearest ptr wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id = '0;
    for (int k = G_NREQ - 1; k >= 0; k--)
      if (active[(int'(ptr) + k) % G_NREQ]) begin
        gnt_vld = 1'b1;
        gnt_id = IW'((int'(ptr) + k) % G_NREQ);
      end
  end
  // clear sequencer: drain outstanding reads before handing the RAM to its clear engine
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (clren) state_nx = DRAIN;
      DRAIN:   if (!(|tag_vld)) state_nx = CLR;
      CLR:     state_nx = WAIT;
      WAIT:    if (!wait_first && mem_clrrdy) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end
  // registered memory port, tag pipeline aligned with the RAM read latency, and FSM state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      ptr <= '0;
      wait_first <= 1'b0;
      mem_clren <= 1'b0;
      memwe <= 1'b0;
      memre <= 1'b0;
      memad <= '0;
      memdi <= '0;
      tag_vld <= '0;
      for (int s = 0; s <= G_LAT; s++) tag_id[s] <= '0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      wait_first <= state == CLR;
      mem_clren <= state_nx == CLR;
      memwe <= gnt_wr;
      memre <= gnt_vld & ~gnt_wr;
      if (gnt_vld) begin
        memad <= req_ad[int'(gnt_id) * G_ADDR +: G_ADDR];
        memdi <= req_di[int'(gnt_id) * G_WIDTH +: G_WIDTH];
      end
      tag_vld <= {tag_vld[G_LAT-1:0], gnt_vld & ~gnt_wr};
      tag_id[0] <= gnt_id;
      for (int s = 1; s <= G_LAT; s++) tag_id[s] <= tag_id[s-1];
    end
endmodule

// File: tb/tb_rtlmem_arb.sv
// tb_rtlmem_arb: directed scoreboard bench for the round-robin RAM arbiter
module tb_rtlmem_arb;
  localparam int N = 4, AW = 10, DW = 16;
  logic clk = 1'b0, rst_n = 1'b0, clren = 1'b0;
  logic clrrdy, memwe, memre, mem_clren;
  logic mem_clrrdy = 1'b1;
  logic [N-1:0] req_re = '0, req_we = '0, req_gnt, rsp_vld;
  logic [N*AW-1:0] req_ad = '0;
  logic [N*DW-1:0] req_di = '0;
  logic [DW-1:0] rsp_do, memdi, memdo;
  logic [AW-1:0] memad;
  typedef struct {int id; logic [DW-1:0] data; int due;} exp_t;
  exp_t q[$];
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] ram [1024];
  logic [DW-1:0] p0, p1;
  logic ram_init = 1'b0;
  int clr_cnt = 0, cyc = 0, checks = 0, errors = 0;
  logic pwe = 1'b0, pre = 1'b0;
  logic [AW-1:0] pad = '0;
  logic [DW-1:0] pdi = '0;

  rtlmem_arb dut (
    .clk(clk), .rst_n(rst_n), .clren(clren), .clrrdy(clrrdy),
    .req_re(req_re), .req_we(req_we), .req_ad(req_ad), .req_di(req_di),
    .req_gnt(req_gnt), .rsp_vld(rsp_vld), .rsp_do(rsp_do),
    .memad(memad), .memwe(memwe), .memdi(memdi), .memre(memre), .memdo(memdo),
    .mem_clren(mem_clren), .mem_clrrdy(mem_clrrdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // write-first RAM with 3-cycle read latency and a clear engine whose ready lags by a cycle
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] = 16'(i * 7 + 3);
      ram_init <= 1'b1;
    end
    if (mem_clren) begin
      for (int i = 0; i < 1024; i++) ram[i] = '0;
      clr_cnt <= 4;
    end else if (clr_cnt != 0) clr_cnt <= clr_cnt - 1;
    mem_clrrdy <= clr_cnt == 0;
    if (memwe) ram[memad] = memdi;
    p0 <= memre ? ram[memad] : 16'hDEAD;
    p1 <= p0;
    memdo <= p1;
  end

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_rsp();
    logic [N-1:0] ev = '0;
    logic [DW-1:0] ed = '0;
    if (q.size() != 0 && q[0].due == cyc) begin
      ev = N'(1) << q[0].id;
      ed = q[0].data;
      void'(q.pop_front());
    end
    chk(32'(rsp_vld), 32'(ev), "rsp_vld");
    if (ev != 0) chk(32'(rsp_do), 32'(ed), "rsp_do");
    else if (q.size() == 0) chk(32'(rsp_do), 0, "rsp_do_idle");
  endtask

  task automatic set_req(input int i, input logic re, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] di);
    req_re[i] = re;
    req_we[i] = we;
    req_ad[i*AW +: AW] = ad;
    req_di[i*DW +: DW] = di;
  endtask

  task automatic step(input logic [N-1:0] eg, input logic erdy, input logic eclr, input string tag);
    @(negedge clk);
    check_rsp();
    chk(32'(req_gnt), 32'(eg), {tag, "_gnt"});
    chk(32'(clrrdy), 32'(erdy), {tag, "_clrrdy"});
    chk(32'(mem_clren), 32'(eclr), {tag, "_mem_clren"});
    chk(32'(memwe), 32'(pwe), {tag, "_memwe"});
    chk(32'(memre), 32'(pre), {tag, "_memre"});
    if (pwe || pre) chk(32'(memad), 32'(pad), {tag, "_memad"});
    if (pwe) chk(32'(memdi), 32'(pdi), {tag, "_memdi"});
    pwe = 1'b0;
    pre = 1'b0;
    for (int i = 0; i < N; i++)
      if (eg[i]) begin
        pad = req_ad[i*AW +: AW];
        pdi = req_di[i*DW +: DW];
        pwe = req_we[i];
        pre = !req_we[i];
        if (req_we[i]) ref_mem[pad] = pdi;
        else q.push_back('{i, ref_mem[pad], cyc + 4});
      end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b1, 1'b0, "idle");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 16'(i * 7 + 3);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 10'(16'h100 + i), '0);
    @(negedge clk);
    check_rsp();
    chk(32'(req_gnt), 0, "reset_gnt");
    chk(32'(clrrdy), 1, "reset_clrrdy");
    chk(32'(memwe), 0, "reset_memwe");
    chk(32'(memre), 0, "reset_memre");
    chk(32'(memad), 0, "reset_memad");
    chk(32'(memdi), 0, "reset_memdi");
    chk(32'(mem_clren), 0, "reset_mem_clren");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) step(N'(1) << (k % N), 1'b1, 1'b0, "rr");
    req_re = '0;
    idle(5);
    set_req(2, 1'b0, 1'b1, 10'h005, 16'hBEEF);
    step(4'b0100, 1'b1, 1'b0, "raw_wr");
    req_we = '0;
    set_req(0, 1'b1, 1'b0, 10'h005, '0);
    step(4'b0001, 1'b1, 1'b0, "raw_rd");
    req_re = '0;
    idle(5);
    set_req(1, 1'b1, 1'b1, 10'h010, 16'h1234);
    step(4'b0010, 1'b1, 1'b0, "rw_wr");
    req_we = '0;
    step(4'b0010, 1'b1, 1'b0, "rw_rd");
    req_re = '0;
    idle(5);
    set_req(2, 1'b1, 1'b0, 10'h102, '0);
    set_req(3, 1'b1, 1'b0, 10'h103, '0);
    set_req(0, 1'b1, 1'b0, 10'h100, '0);
    step(4'b0100, 1'b1, 1'b0, "clr_rd2");
    req_re[2] = 1'b0;
    step(4'b1000, 1'b1, 1'b0, "clr_rd3");
    req_re[3] = 1'b0;
    step(4'b0001, 1'b1, 1'b0, "clr_rd0");
    req_re[0] = 1'b0;
    set_req(1, 1'b1, 1'b0, 10'h101, '0);
    clren = 1'b1;
    step('0, 1'b1, 1'b0, "clren");
    clren = 1'b0;
    for (int k = 0; k < 11; k++) step('0, 1'b0, k == 4, "clearing");
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    step(4'b0010, 1'b1, 1'b0, "resume");
    req_re = '0;
    idle(5);
    set_req(2, 1'b1, 1'b0, 10'h102, '0);
    step(4'b0100, 1'b1, 1'b0, "rst_rd");
    void'(q.pop_back());
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 10'(16'h100 + i), '0);
    rst_n = 1'b0;
    pwe = 1'b0;
    pre = 1'b0;
    @(negedge clk);
    check_rsp();
    chk(32'(req_gnt), 0, "in_rst_gnt");
    chk(32'(memre), 0, "in_rst_memre");
    chk(32'(clrrdy), 1, "in_rst_clrrdy");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b0001, 1'b1, 1'b0, "post_rst");
    req_re = '0;
    set_req(3, 1'b1, 1'b0, 10'h103, '0);
    step(4'b1000, 1'b1, 1'b0, "single3");
    req_re = '1;
    step(4'b0001, 1'b1, 1'b0, "ptr_wrap");
    req_re = '0;
    idle(6);
    chk(32'(q.size()), 0, "sb_empty");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
